// File: rtl/bcm_pkg.sv
// Shared constants and helpers for the BCM LED-matrix frame store.
// Colour indices follow the UART byte order within a pixel.
package bcm_pkg;

    localparam int CLR_R = 0;
    localparam int CLR_G = 1;
    localparam int CLR_B = 2;
    localparam int BYTES_PER_PIXEL = 3;

    // Never returns 0 so that derived vector widths stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/bcm_frame_store_if.sv
// UART write stream and plane-read port of the BCM frame store.
// Master is the producer/scan side, slave is the frame store.
interface bcm_frame_store_if
    import bcm_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 32,
    parameter int BPC  = 8
);
    localparam int RW = clog2(ROWS / 2);
    localparam int PW = clog2(BPC);

    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            wr_sync;
    logic            frame_done;
    logic            rd_req;
    logic [RW-1:0]   rd_row;
    logic [PW-1:0]   rd_plane;
    logic            rd_valid;
    logic [COLS-1:0] r1, g1, b1;
    logic [COLS-1:0] r2, g2, b2;

    modport master (
        output rx_data, rx_valid, wr_sync, rd_req, rd_row, rd_plane,
        input  frame_done, rd_valid, r1, g1, b1, r2, g2, b2
    );

    modport slave (
        input  rx_data, rx_valid, wr_sync, rd_req, rd_row, rd_plane,
        output frame_done, rd_valid, r1, g1, b1, r2, g2, b2
    );

endinterface

// File: rtl/bcm_wr_sequencer.sv
// Write pointer for the frame store: colour phase, column and row
// counters, resync handling and the end-of-frame pulse.
module bcm_wr_sequencer
    import bcm_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid_i,
    input  logic                   wr_sync_i,
    output logic                   we_o,
    output logic [1:0]             phase_o,
    output logic [clog2(COLS)-1:0] col_o,
    output logic [clog2(ROWS)-1:0] row_o,
`ifdef BCM_DOUBLE_BUFFER_EN
    output logic                   swap_o,
`endif
    output logic                   frame_done_o
);
    localparam int CW = clog2(COLS);
    localparam int RW = clog2(ROWS);

    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          fd_q, fd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            col_q   <= col_d;
            row_q   <= row_d;
            fd_q    <= fd_d;
        end
    end

    // Resync wins over a byte strobed in the same cycle.
    always_comb begin
        phase_d = phase_q;
        col_d   = col_q;
        row_d   = row_q;
        fd_d    = 1'b0;
        if (wr_sync_i) begin
            phase_d = '0;
            col_d   = '0;
            row_d   = '0;
        end else if (rx_valid_i) begin
            if (phase_q == 2'(BYTES_PER_PIXEL - 1)) begin
                phase_d = '0;
                if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d = '0;
                        fd_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    assign we_o         = rx_valid_i & ~wr_sync_i;
    assign phase_o      = phase_q;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign frame_done_o = fd_q;
`ifdef BCM_DOUBLE_BUFFER_EN
    assign swap_o       = fd_d;
`endif

endmodule

// File: rtl/bcm_frame_store.sv
// Bit-plane frame store for the BCM matrix driver; BCM_DOUBLE_BUFFER_EN
// selects front/back buffering, otherwise writes land in the shown frame.
module bcm_frame_store
    import bcm_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 32,
    parameter int BPC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bcm_frame_store_if.slave bus
);
    localparam int CW  = clog2(COLS);
    localparam int RWF = clog2(ROWS);
    localparam int PW  = clog2(BPC);

    typedef logic [COLS-1:0] word_t;

    logic           we;
    logic [1:0]     phase;
    logic [CW-1:0]  col;
    logic [RWF-1:0] row;
    logic           wbuf, rbuf;

`ifdef BCM_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
    logic swap;
    logic front_q, front_d;

    assign front_d = front_q ^ swap;
    assign wbuf    = ~front_q;
    assign rbuf    = front_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) front_q <= 1'b0;
        else        front_q <= front_d;
    end
`else
    localparam int NBUF = 1;
    assign wbuf = 1'b0;
    assign rbuf = 1'b0;
`endif

    bcm_wr_sequencer #(.COLS(COLS), .ROWS(ROWS)) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid_i   (bus.rx_valid),
        .wr_sync_i    (bus.wr_sync),
        .we_o         (we),
        .phase_o      (phase),
        .col_o        (col),
        .row_o        (row),
`ifdef BCM_DOUBLE_BUFFER_EN
        .swap_o       (swap),
`endif
        .frame_done_o (bus.frame_done)
    );

    word_t          mem_q [NBUF][BYTES_PER_PIXEL][BPC][ROWS];
    logic [BPC-1:0] bits;

    // Plane p takes byte bit 8-BPC+p, i.e. only the BPC MSBs survive.
    assign bits = bus.rx_data[7 -: BPC];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int p = 0; p < BPC; p++)
                mem_q[wbuf][phase][p[PW-1:0]][row][col] <= bits[p[PW-1:0]];
        end
    end

    logic           rd_ok;
    logic [RWF-1:0] up_row, lo_row;
    logic           rd_valid_q;
    word_t          r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;

    assign rd_ok  = (int'(bus.rd_plane) < BPC) && (int'(bus.rd_row) < ROWS / 2);
    assign up_row = RWF'(bus.rd_row);
    assign lo_row = up_row + RWF'(ROWS / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            r1_q <= '0;
            g1_q <= '0;
            b1_q <= '0;
            r2_q <= '0;
            g2_q <= '0;
            b2_q <= '0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                r1_q <= rd_ok ? mem_q[rbuf][2'(CLR_R)][bus.rd_plane][up_row] : '0;
                g1_q <= rd_ok ? mem_q[rbuf][2'(CLR_G)][bus.rd_plane][up_row] : '0;
                b1_q <= rd_ok ? mem_q[rbuf][2'(CLR_B)][bus.rd_plane][up_row] : '0;
                r2_q <= rd_ok ? mem_q[rbuf][2'(CLR_R)][bus.rd_plane][lo_row] : '0;
                g2_q <= rd_ok ? mem_q[rbuf][2'(CLR_G)][bus.rd_plane][lo_row] : '0;
                b2_q <= rd_ok ? mem_q[rbuf][2'(CLR_B)][bus.rd_plane][lo_row] : '0;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.r1       = r1_q;
    assign bus.g1       = g1_q;
    assign bus.b1       = b1_q;
    assign bus.r2       = r2_q;
    assign bus.g2       = g2_q;
    assign bus.b2       = b2_q;

endmodule

// File: tb/tb_bcm_frame_store.sv
// Self-checking bench for bcm_frame_store: pixel-level model plus
// a constant read table for hand-placed pixels.
module tb_bcm_frame_store;
    import bcm_pkg::*;

    localparam int COLS  = 64;
    localparam int ROWS  = 32;
    localparam int BPC   = 8;
    localparam int HR    = ROWS / 2;
    localparam int FRAME = COLS * ROWS * BYTES_PER_PIXEL;
`ifdef BCM_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    typedef logic [5:0][COLS-1:0] words_t;
    typedef struct {
        int     row;
        int     plane;
        words_t exp;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bcm_frame_store_if #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC)) bus ();

    bcm_frame_store #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    bit [7:0] img [2][ROWS][COLS][3];
    int mph, mcol, mrow, mfront;
    words_t pend;
    words_t sb[$];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    function automatic words_t mkw(input logic [63:0] r1, g1, b1, r2, g2, b2);
        return {b2, g2, r2, b1, g1, r1};
    endfunction

    function automatic words_t model_words(input int row, input int plane);
        words_t w;
        w = '0;
        if (plane < BPC && row < HR)
            for (int k = 0; k < 6; k++)
                for (int c = 0; c < COLS; c++)
                    w[k][c] = img[mfront][(k < 3) ? row : row + HR][c][k % 3][8 - BPC + plane];
        return w;
    endfunction

    function automatic logic [7:0] gen(input int kind);
        if (kind == 0) return 8'h00;
        if (kind == 1) begin
            if (mrow == 0 && mcol == 0 && mph == CLR_R) return 8'h80;
            if (mrow == 16 && mcol == 63 && mph == CLR_B) return 8'hFF;
            if (mrow == 5 && mcol == 10 && mph == CLR_G) return 8'h55;
            if (mrow == 21 && mcol == 10 && mph == CLR_R) return 8'hA0;
            return 8'h00;
        end
        return 8'($urandom);
    endfunction

    task automatic chk_words(input string tag, input words_t e);
        chk({tag, ".r1"}, bus.r1, e[0]);
        chk({tag, ".g1"}, bus.g1, e[1]);
        chk({tag, ".b1"}, bus.b1, e[2]);
        chk({tag, ".r2"}, bus.r2, e[3]);
        chk({tag, ".g2"}, bus.g2, e[4]);
        chk({tag, ".b2"}, bus.b2, e[5]);
    endtask

    // One clock: the model sees this cycle's strobes, then outputs are checked.
    task automatic tick();
        bit fd;
        bit rq;
        fd = 1'b0;
        rq = bus.rd_req;
        if (bus.rd_req) sb.push_back(pend);
        if (bus.wr_sync) begin
            mph = 0; mcol = 0; mrow = 0;
        end else if (bus.rx_valid) begin
            img[DBL ? 1 - mfront : mfront][mrow][mcol][mph] = bus.rx_data;
            mph++;
            if (mph == 3) begin
                mph = 0; mcol++;
                if (mcol == COLS) begin
                    mcol = 0; mrow++;
                    if (mrow == ROWS) begin
                        mrow = 0; fd = 1'b1;
                        if (DBL) mfront = 1 - mfront;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.wr_sync  = 1'b0;
        bus.rd_req   = 1'b0;
        chk("frame_done", 64'(bus.frame_done), 64'(fd));
        chk("rd_valid", 64'(bus.rd_valid), 64'(rq));
        if (bus.rd_valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_empty: got rd_valid=1 want no read pending");
            end else begin
                chk_words("rd", sb.pop_front());
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        tick();
    endtask

    task automatic rd_model(input int row, input int plane);
        bus.rd_req   = 1'b1;
        bus.rd_row   = 4'(row);
        bus.rd_plane = 3'(plane);
        pend = model_words(row, plane);
        tick();
    endtask

    task automatic send_frame(input int kind, input bit rd_each, output int fd_at);
        fd_at = -1;
        for (int i = 0; i < FRAME + 4; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = gen(kind);
            if (rd_each) begin
                bus.rd_req   = 1'b1;
                bus.rd_row   = 4'(i % HR);
                bus.rd_plane = 3'((i / HR) % BPC);
                pend = model_words(i % HR, (i / HR) % BPC);
            end
            tick();
            if (bus.frame_done) begin
                fd_at = i + 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        chk("rst.frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst.rd_valid", 64'(bus.rd_valid), 64'd0);
        chk_words("rst", '0);
        mph = 0; mcol = 0; mrow = 0; mfront = 0;
        sb.delete();
        rst_n = 1'b1;
    endtask

    rd_vec_t tab [9];
    int fd_at;

    initial begin
        logic [63:0] b63, c10;
        b63 = 64'h8000_0000_0000_0000;
        c10 = 64'h0000_0000_0000_0400;
        tab[0] = '{0, 7, mkw(64'h1, 0, 0, 0, 0, b63)};
        tab[1] = '{0, 6, mkw(0, 0, 0, 0, 0, b63)};
        tab[2] = '{0, 0, mkw(0, 0, 0, 0, 0, b63)};
        tab[3] = '{1, 3, mkw(0, 0, 0, 0, 0, 0)};
        tab[4] = '{5, 0, mkw(0, c10, 0, 0, 0, 0)};
        tab[5] = '{5, 1, mkw(0, 0, 0, 0, 0, 0)};
        tab[6] = '{5, 5, mkw(0, 0, 0, c10, 0, 0)};
        tab[7] = '{5, 6, mkw(0, c10, 0, 0, 0, 0)};
        tab[8] = '{5, 7, mkw(0, 0, 0, c10, 0, 0)};

        bus.rx_data = '0; bus.rx_valid = 1'b0; bus.wr_sync = 1'b0;
        bus.rd_req = 1'b0; bus.rd_row = '0; bus.rd_plane = '0;
        pend = '0;
        #2;
        do_reset();

        send_frame(0, 1'b0, fd_at);
        chk("fd_count_zero", 64'(fd_at), 64'(FRAME));
        rd_model(0, 0);

        send_frame(1, 1'b0, fd_at);
        chk("fd_count_wrap", 64'(fd_at), 64'(FRAME));
        for (int i = 0; i < 9; i++) begin
            bus.rd_req   = 1'b1;
            bus.rd_row   = 4'(tab[i].row);
            bus.rd_plane = 3'(tab[i].plane);
            pend = tab[i].exp;
            tick();
        end
        tick();
        tick();
        chk("hold.r2", bus.r2, c10);

        for (int i = 0; i < 50; i++) send(gen(2));
        do_reset();
        send_frame(2, 1'b0, fd_at);
        chk("fd_count_after_rst", 64'(fd_at), 64'(FRAME));
        rd_model(3, 4);
        rd_model(15, 7);

        for (int i = 0; i < 100; i++) send(gen(2));
        bus.wr_sync  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hFF;
        tick();
        send_frame(2, 1'b0, fd_at);
        chk("fd_count_sync", 64'(fd_at), 64'(FRAME));
        rd_model(0, 7);

        send_frame(2, 1'b1, fd_at);
        chk("fd_count_rd_each", 64'(fd_at), 64'(FRAME));
        rd_model(7, 2);
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcm_frame_store.md
# bcm_frame_store

Parametrised double-buffered frame store for the BCM LED-matrix driver. It accepts the UART byte stream (R, G, B per pixel, row-major), scatters each byte into bit-plane words, and on request returns one bit-plane of an upper/lower row pair as six COLS-wide words. It sits between the UART receiver and the BCM scan/timing engine. It generalises the fixed 64-column controller in three ways: columns, rows and colour depth are parameters; a front/back buffer swap happens at frame boundaries; and a resync input is provided.

## Interface
- COLS, 64, pixels per row; width of every colour output word.
- ROWS, 32, panel rows; upper half is rows 0..ROWS/2-1, lower half is ROWS/2..ROWS-1.
- BPC, 8, bits per colour kept (1..8); the BPC MSBs of each byte are stored.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe: rx_data valid.
- wr_sync  in  1  one-cycle strobe: restart write pointer at pixel 0, R.
- frame_done  out  1  one-cycle pulse: last byte of a frame written.
- rd_req  in  1  read strobe.
- rd_row  in  clog2(ROWS/2)  row-pair index.
- rd_plane  in  clog2(BPC)  bit-plane; 0 = least significant kept bit.
- rd_valid  out  1  one-cycle pulse: read data valid.
- r1, g1, b1  out  COLS each  upper-row plane word; bit c = column c.
- r2, g2, b2  out  COLS each  lower-row plane word (row rd_row+ROWS/2).

## Operation
- Storage is a register array of 2 buffers × 3 colours × BPC planes × ROWS words, each COLS bits wide.
- Storage is not reset. The front/back select resets to buffer 0 = front.
- Write sequencer counters:
  - phase: 0..2, order R, G, B.
  - col: 0..COLS-1.
  - row: 0..ROWS-1.
  - All reset to 0.
- Accepted byte (rx_valid=1, wr_sync=0): for each plane p, bit col of word [back][phase][p][row] is written with rx_data[8-BPC+p]. The counters then advance with phase fastest, then col, then row.
- Last byte (phase=2, col=COLS-1, row=ROWS-1):
  - all counters wrap to 0;
  - frame_done pulses;
  - front/back toggles.
- wr_sync=1: all counters clear to 0. wr_sync has priority: a byte strobed in the same cycle is dropped. No swap and no frame_done.
- Read: rd_req samples rd_row and rd_plane. The six outputs are registered from the front buffer, planes [c][rd_plane][rd_row] and [c][rd_plane][rd_row+ROWS/2].
- Outputs hold their value until the next rd_req.
- rd_plane ≥ BPC or rd_row ≥ ROWS/2: the outputs load zero and rd_valid still pulses.
- Reset mid-frame: counters and select return to 0; the partial frame is discarded.

## Timing
- Reset values:
  - frame_done = 0, rd_valid = 0.
  - All six colour words = 0.
- Write latency: a byte strobed in cycle n is in storage at edge n. In single-buffer mode it is visible to an rd_req in cycle n+1.
- frame_done and the swap are registered at the same edge as the last byte write. An rd_req in the cycle frame_done is high reads the new front.
- Read latency 1: rd_req in cycle n gives rd_valid high and data valid in cycle n+1.
- Back-to-back rd_req is allowed every cycle.
- rd_req concurrent with a write to the front buffer (single-buffer mode) returns pre-write data.
- rx_valid may assert every cycle. There is no backpressure.

## Configuration
- BCM_DOUBLE_BUFFER_EN defined:
  - two buffers;
  - writes go to the back buffer;
  - reads use the front buffer;
  - the swap happens at frame_done.
- Undefined:
  - one buffer, no select bit;
  - writes go directly to the displayed buffer (tearing is permitted);
  - frame_done still pulses.

## Structure
- bcm_pkg:
  - colour index constants CLR_R=0, CLR_G=1, CLR_B=2;
  - BYTES_PER_PIXEL=3;
  - the clog2 helper function.
- Sub-module bcm_wr_sequencer holds the phase/col/row counters, wr_sync handling and frame_done generation. The top level holds storage, the buffer select and the read registers.

## Test plan
- Reset: assert rst_n=0 mid-run → all outputs 0; first rd_req(row 0, plane 0) → rd_valid the next cycle, words 0 after a frame of zeros.
- Defaults: frame with pixel (0,0) R=0x80, all else 0 → after frame_done, rd_req(0,7) gives r1=64'h1, all other words 0; rd_req(0,6) gives r1=0.
- Pixel (row 16, col 63) B=0xFF → rd_req(0,p) for every p gives b2=64'h8000_0000_0000_0000; b1=0.
- frame_done pulses exactly after 6144 bytes. A second frame wraps: its byte 0 lands at pixel 0, R.
- wr_sync after 100 bytes, with rx_valid in the same cycle → that byte is dropped; frame_done follows exactly 6144 further bytes.
- With BCM_DOUBLE_BUFFER_EN: mid-frame-2 reads return frame-1 data until frame_done. Without it: a read 1 cycle after a byte shows the new bit.
